// File: rtl/distance1_pkg.sv
// Shared constants for the distance1 LBIST signature comparator.
package distance1_pkg;
    localparam int SIG_W = 8;
    localparam int CNT_W = 8;
endpackage

// File: rtl/distance1_popcount.sv
// Combinational balanced adder tree counting the ones in a WIDTH-bit vector.
module distance1_popcount
    import distance1_pkg::*;
#(
    parameter int WIDTH = SIG_W
) (
    input  logic [WIDTH-1:0] bits_i,
    output logic [CNT_W-1:0] count_o
);
    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int LEAVES = 1 << LEVELS;

    // Heap-ordered tree: node k has children 2k+1 and 2k+2, leaves start at LEAVES-1.
    logic [CNT_W-1:0] node [0:2*LEAVES-2];

    genvar gi;
    generate
        for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
            if (gi < WIDTH) begin : g_bit
                assign node[LEAVES-1+gi] = CNT_W'(bits_i[gi]);
            end else begin : g_pad
                assign node[LEAVES-1+gi] = '0;
            end
        end
        for (gi = 0; gi < LEAVES-1; gi++) begin : g_sum
            assign node[gi] = node[2*gi+1] + node[2*gi+2];
        end
    endgenerate

    assign count_o = node[0];
endmodule

// File: rtl/distance1.sv
// LBIST signature comparator: registered XOR failing-bit map and Hamming distance.
// Optional macro DISTANCE1_STICKY_EN turns RED_SIG into a fault map sticky until RST.
module distance1
    import distance1_pkg::*;
#(
    parameter int WIDTH = SIG_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SIG_IN,
    input  logic [WIDTH-1:0] SIG_OUT,
    output logic [CNT_W-1:0] NUMBER,
    output logic [WIDTH-1:0] RED_SIG
);
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] red_sig_d;
    logic [WIDTH-1:0] red_sig_q;
    logic [CNT_W-1:0] number_d;
    logic [CNT_W-1:0] number_q;

    assign diff = SIG_IN ^ SIG_OUT;

`ifdef DISTANCE1_STICKY_EN
    assign red_sig_d = red_sig_q | diff;
`else
    assign red_sig_d = diff;
`endif

    // Counting the next map keeps NUMBER and RED_SIG describing the same state.
    distance1_popcount #(.WIDTH(WIDTH)) u_popcount (
        .bits_i  (red_sig_d),
        .count_o (number_d)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            red_sig_q <= '0;
            number_q  <= '0;
        end else begin
            red_sig_q <= red_sig_d;
            number_q  <= number_d;
        end
    end

    assign RED_SIG = red_sig_q;
    assign NUMBER  = number_q;
endmodule

// File: tb/tb_distance1.sv
// Self-checking bench for distance1: directed vectors plus random pairs against a reference model.
module tb_distance1;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] SIG_IN = '0;
    logic [7:0] SIG_OUT = '0;
    logic [7:0] NUMBER;
    logic [7:0] RED_SIG;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] model_red = '0;

    distance1 #(.WIDTH(8)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SIG_IN  (SIG_IN),
        .SIG_OUT (SIG_OUT),
        .NUMBER  (NUMBER),
        .RED_SIG (RED_SIG)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] count_ones(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) if (v[i]) n++;
        return 8'(n);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Drive one pair for one edge, then compare both outputs with the model.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic r, input string tag);
        @(negedge CLK);
        SIG_IN  = a;
        SIG_OUT = b;
        RST     = r;
        @(posedge CLK);
        if (r) model_red = '0;
`ifdef DISTANCE1_STICKY_EN
        else model_red = model_red | (a ^ b);
`else
        else model_red = a ^ b;
`endif
        #1;
        $display("[TB] %s rst=%0b in=0x%02h out=0x%02h -> red=0x%02h num=%0d", tag, r, a, b, RED_SIG, NUMBER);
        chk({tag, "_red"}, RED_SIG, model_red);
        chk({tag, "_num"}, NUMBER, count_ones(model_red));
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rr;

        step(8'd54, 8'd22, 1'b1, "reset");
        chk("reset_red_zero", RED_SIG, 8'h00);
        chk("reset_num_zero", NUMBER, 8'd0);

`ifdef DISTANCE1_STICKY_EN
        step(8'd235, 8'd43, 1'b0, "sticky1");
        chk("sticky1_red_const", RED_SIG, 8'hC0);
        chk("sticky1_num_const", NUMBER, 8'd2);
        step(8'd35, 8'd53, 1'b0, "sticky2");
        chk("sticky2_red_const", RED_SIG, 8'hD6);
        chk("sticky2_num_const", NUMBER, 8'd5);
        step(8'h00, 8'hFF, 1'b0, "sticky_all");
        chk("sticky_all_num_const", NUMBER, 8'd8);
        step(8'd1, 8'd2, 1'b1, "sticky_clear");
        step(8'hA5, 8'hA5, 1'b0, "sticky_match");
        chk("sticky_match_num_const", NUMBER, 8'd0);
`else
        step(8'd235, 8'd43, 1'b0, "pair1");
        chk("pair1_red_const", RED_SIG, 8'hC0);
        chk("pair1_num_const", NUMBER, 8'd2);
        step(8'd35, 8'd53, 1'b0, "pair2");
        chk("pair2_red_const", RED_SIG, 8'h16);
        chk("pair2_num_const", NUMBER, 8'd3);
        step(8'd64, 8'd84, 1'b0, "pair3");
        chk("pair3_red_const", RED_SIG, 8'h14);
        chk("pair3_num_const", NUMBER, 8'd2);
        step(8'd20, 8'd63, 1'b0, "pair4");
        chk("pair4_red_const", RED_SIG, 8'h2B);
        chk("pair4_num_const", NUMBER, 8'd4);
        step(8'd64, 8'd64, 1'b0, "match");
        chk("match_num_const", NUMBER, 8'd0);
        step(8'h00, 8'hFF, 1'b0, "compl");
        chk("compl_red_const", RED_SIG, 8'hFF);
        chk("compl_num_const", NUMBER, 8'd8);
        step(8'hA5, 8'hA5, 1'b0, "extreme_match");
        chk("extreme_match_red_const", RED_SIG, 8'h00);
`endif

        // Mid-stream reset with inputs still changing, then normal results resume.
        step(8'h0F, 8'hF0, 1'b0, "pre_rst");
        step(8'h3C, 8'h81, 1'b1, "mid_rst");
        chk("mid_rst_red_zero", RED_SIG, 8'h00);
        step(8'h3C, 8'h81, 1'b0, "post_rst");

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rr = ($urandom_range(0, 15) == 0);
            step(ra, rb, rr, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
